// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and helpers for the AES block I/O buffers.
package fifo_pkg;

   localparam int unsigned FifoWidth = 128;
   localparam int unsigned FifoDepth = 32;

   // One AES state block as carried through the host I/O FIFOs.
   typedef logic [127:0] aes_block_t;

   // Pointer/count width: index bits plus one wrap bit.
   function automatic int unsigned cw_f(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x WIDTH flop array with one write port and one asynchronous read port.
module fifo_mem_2p
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = FifoWidth,
   parameter int unsigned DEPTH = FifoDepth,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage is intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_hs.sv
// Synchronous FWFT FIFO with valid/ready handshake on both sides, occupancy
// count, programmable almost-flags and synchronous flush.
module fifo_sync_hs
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH    = FifoWidth,
   parameter int unsigned DEPTH    = FifoDepth,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2,
   localparam int unsigned CW      = cw_f(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             almost_full_o,
   output logic             almost_empty_o
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("fifo_sync_hs: DEPTH must be a power of 2 and >= 2");
   end
   if (WIDTH < 1) begin : g_width_check
      $error("fifo_sync_hs: WIDTH must be >= 1");
   end

   logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             afull_q, afull_d;
   logic             aempty_q, aempty_d;
   logic             push, pop;
   logic [WIDTH-1:0] rdata;

   // Handshakes see only registered flags, so no ready->valid combinational path.
   assign push = in_valid_i & ~full_q;
   assign pop  = out_ready_i & ~empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + CW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + CW'(1);
      end
      // Wrap bit makes the difference span 0..DEPTH.
      count_d  = wr_ptr_d - rd_ptr_d;
      full_d   = (count_d == CW'(DEPTH));
      empty_d  = (count_d == '0);
      afull_d  = (32'(count_d) >= AF_LEVEL);
      aempty_d = (32'(count_d) <= AE_LEVEL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= (AF_LEVEL == 0);
         aempty_q <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
      end
   end

   fifo_mem_2p #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) u_mem (
      .clk_i  (clk),
      .we_i   (push & ~flush_i),
      .waddr_i(wr_ptr_q[CW-2:0]),
      .wdata_i(in_data_i),
      .raddr_i(rd_ptr_q[CW-2:0]),
      .rdata_o(rdata)
   );

   assign in_ready_o     = ~full_q;
   assign out_valid_o    = ~empty_q;
   assign out_data_o     = empty_q ? '0 : rdata;
   assign count_o        = count_q;
   assign full_o         = full_q;
   assign empty_o        = empty_q;
   assign almost_full_o  = afull_q;
   assign almost_empty_o = aempty_q;

endmodule

// File: tb/tb_fifo_sync_hs.sv
// Directed and randomized bench for fifo_sync_hs against a queue-based model.
module tb_fifo_sync_hs;

   localparam int unsigned W   = 128;
   localparam int unsigned D   = 32;
   localparam int unsigned AF  = 30;
   localparam int unsigned AE  = 2;
   localparam int unsigned CW  = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
   logic [CW-1:0] count;
   logic          full, empty, afull, aempty;

   logic [W-1:0]  model_q[$];
   int            vectors = 0;
   int            miscompares = 0;

   always #5 clk = ~clk;

   fifo_sync_hs #(
      .WIDTH   (W),
      .DEPTH   (D),
      .AF_LEVEL(AF),
      .AE_LEVEL(AE)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush_i       (flush),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .in_data_i     (in_data),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_data_o    (out_data),
      .count_o       (count),
      .full_o        (full),
      .empty_o       (empty),
      .almost_full_o (afull),
      .almost_empty_o(aempty)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      int unsigned n;
      logic [W-1:0] head;
      n    = model_q.size();
      head = (n > 0) ? model_q[0] : '0;
      chk({ph, ".count"},     W'(count),     W'(n));
      chk({ph, ".empty"},     W'(empty),     W'(n == 0));
      chk({ph, ".full"},      W'(full),      W'(n == D));
      chk({ph, ".in_ready"},  W'(in_ready),  W'(n != D));
      chk({ph, ".out_valid"}, W'(out_valid), W'(n != 0));
      chk({ph, ".out_data"},  out_data,      head);
      chk({ph, ".afull"},     W'(afull),     W'(n >= AF));
      chk({ph, ".aempty"},    W'(aempty),    W'(n <= AE));
   endtask

   function automatic logic [W-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drive one cycle; outputs are checked at the negedge before new inputs apply.
   task automatic step(input string ph, input logic v, input logic [W-1:0] d,
                       input logic r, input logic f);
      bit do_push, do_pop;
      @(negedge clk);
      check_all(ph);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      do_push   = v && (model_q.size() < D);
      do_pop    = r && (model_q.size() > 0);
      @(posedge clk);
      if (f) begin
         model_q.delete();
      end else begin
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back(d);
      end
   endtask

   initial begin
      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;

      // Fill with 0x01..0x20 plus a refused 33rd push
      for (int i = 1; i <= 33; i++) step("fill", 1'b1, W'(i), 1'b0, 1'b0);

      // Drain in order, one per cycle, plus an extra pop on empty
      for (int i = 0; i < 33; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);

      // Empty + push + ready: push only
      step("empty_pp", 1'b1, rnd_word(), 1'b1, 1'b0);
      step("empty_pp", 1'b0, '0, 1'b1, 1'b0);

      // Steady occupancy of 5 across three pointer wraps
      for (int i = 0; i < 5; i++) step("pre5", 1'b1, rnd_word(), 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) step("steady5", 1'b1, rnd_word(), 1'b1, 1'b0);

      // Full with push+pop: pop only, then the freed slot accepts a push
      while (model_q.size() < D) step("tofull", 1'b1, rnd_word(), 1'b0, 1'b0);
      step("full_pp", 1'b1, rnd_word(), 1'b1, 1'b0);
      step("full_push", 1'b1, rnd_word(), 1'b0, 1'b0);
      step("full_idle", 1'b0, '0, 1'b0, 1'b0);

      // Flush at count 10 overrides push and pop
      for (int i = 0; i < 22; i++) step("to10", 1'b0, '0, 1'b1, 1'b0);
      step("flush", 1'b1, rnd_word(), 1'b1, 1'b1);
      step("post_flush", 1'b0, '0, 1'b0, 1'b0);

      // Asynchronous reset pulse mid-stream
      for (int i = 0; i < 7; i++) step("pre_rst", 1'b1, rnd_word(), 1'b0, 1'b0);
      @(negedge clk);
      check_all("pre_rst_chk");
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      model_q.delete();
      check_all("async_rst");
      #1 rst_n = 1'b1;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom_range(0, 3) != 0), rnd_word(),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
      end
      @(negedge clk);
      check_all("final");
      in_valid  = 1'b0;
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
